// File: rtl/rx_dsp_pkg.sv
// Shared RX datapath definitions: widths, state encoding and saturating add.
package rx_dsp_pkg;

  localparam int unsigned FRAC_BITS    = 15;
  localparam int unsigned DATAWIDTH    = FRAC_BITS + 1;
  localparam int unsigned MULT_LATENCY = 4;
  localparam int unsigned SAT_CALC_W   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic                         sat;
    logic signed [SAT_CALC_W-1:0] val;
  } sat_res_t;

  // Add two sign-extended operands and clamp the result to a w-bit signed range (w <= 63).
  function automatic sat_res_t sat_add(input logic signed [SAT_CALC_W-1:0] a,
                                       input logic signed [SAT_CALC_W-1:0] b,
                                       input int unsigned                  w);
    logic signed [SAT_CALC_W-1:0] sum;
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    sat_res_t                     r;
    sum   = a + b;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    r.sat = 1'b0;
    r.val = sum;
    if (sum > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (sum < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmult_accum_dump_if.sv
// Product input, window control and result handshake of the integrate-and-dump stage.
interface cmult_accum_dump_if #(
  parameter int unsigned DATAWIDTH = rx_dsp_pkg::DATAWIDTH,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 16
);

  logic                        in_valid_i;
  logic signed [DATAWIDTH-1:0] re_i;
  logic signed [DATAWIDTH-1:0] im_i;
  logic                        start_i;
  logic [LEN_WIDTH-1:0]        len_i;
  logic signed [ACC_WIDTH-1:0] acc_re_o;
  logic signed [ACC_WIDTH-1:0] acc_im_o;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic                        busy_o;
  logic                        sat_o;
  logic                        drop_o;

  modport master (
    output in_valid_i, re_i, im_i, start_i, len_i, out_ready_i,
    input  acc_re_o, acc_im_o, out_valid_o, busy_o, sat_o, drop_o
  );

  modport slave (
    input  in_valid_i, re_i, im_i, start_i, len_i, out_ready_i,
    output acc_re_o, acc_im_o, out_valid_o, busy_o, sat_o, drop_o
  );

endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that recreates a valid for a pipelined datapath with no valid of its own.
module valid_delay_line #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift in every cycle; the oldest bit falls off the top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= DEPTH'({sr_q, d_i});
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/cmult_accum_dump.sv
// Integrate-and-dump of complex multiplier products over a programmable window.
module cmult_accum_dump #(
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter int unsigned MULT_LATENCY = rx_dsp_pkg::MULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  cmult_accum_dump_if.slave bus
);

  import rx_dsp_pkg::*;

  state_e                      state_q;
  logic [LEN_WIDTH-1:0]        n_q;
  logic [LEN_WIDTH-1:0]        cnt_q;
  logic signed [ACC_WIDTH-1:0] sum_re_q;
  logic signed [ACC_WIDTH-1:0] sum_im_q;
  logic signed [ACC_WIDTH-1:0] acc_re_q;
  logic signed [ACC_WIDTH-1:0] acc_im_q;
  logic                        out_valid_q;
  logic                        busy_q;
  logic                        sat_q;
  logic                        drop_q;

  sat_res_t                    add_re_d;
  sat_res_t                    add_im_d;
  logic signed [ACC_WIDTH-1:0] sum_re_d;
  logic signed [ACC_WIDTH-1:0] sum_im_d;
  logic                        ovf_d;
  logic                        last_d;
  logic [LEN_WIDTH-1:0]        n_d;
  logic                        prod_valid;
  logic                        unused_hi_bits;

  // Input valid delayed to line up with the multiplier output.
  valid_delay_line #(
    .DEPTH (MULT_LATENCY)
  ) u_valid_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.in_valid_i),
    .q_o   (prod_valid)
  );

  // Saturating next sums, window-end detect and the latched length for a new window.
  always_comb begin
    add_re_d = sat_add(64'(sum_re_q), 64'(bus.re_i), ACC_WIDTH);
    add_im_d = sat_add(64'(sum_im_q), 64'(bus.im_i), ACC_WIDTH);
    sum_re_d = ACC_WIDTH'(add_re_d.val);
    sum_im_d = ACC_WIDTH'(add_im_d.val);
    ovf_d    = add_re_d.sat | add_im_d.sat;
    last_d   = (cnt_q == LEN_WIDTH'(n_q - LEN_WIDTH'(1)));
    n_d      = (bus.len_i == '0) ? LEN_WIDTH'(1) : bus.len_i;
  end

  // Bits above ACC_WIDTH are always the sign extension of a clamped value.
  assign unused_hi_bits = ^{add_re_d.val[SAT_CALC_W-1:ACC_WIDTH],
                            add_im_d.val[SAT_CALC_W-1:ACC_WIDTH]};

  // Window control: IDLE waits for start, ACCUM sums products, HOLD presents the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      cnt_q       <= '0;
      sum_re_q    <= '0;
      sum_im_q    <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            n_q      <= n_d;
            cnt_q    <= '0;
            sum_re_q <= '0;
            sum_im_q <= '0;
            sat_q    <= 1'b0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ACCUM;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            sum_re_q <= sum_re_d;
            sum_im_q <= sum_im_d;
            sat_q    <= sat_q | ovf_d;
            cnt_q    <= cnt_q + LEN_WIDTH'(1);
            if (last_d) begin
              acc_re_q    <= sum_re_d;
              acc_im_q    <= sum_im_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (prod_valid) begin
            drop_q <= 1'b1;
          end
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            if (bus.start_i) begin
              // Back-to-back window: the clear below also wins over a same-cycle drop.
              n_q      <= n_d;
              cnt_q    <= '0;
              sum_re_q <= '0;
              sum_im_q <= '0;
              sat_q    <= 1'b0;
              drop_q   <= 1'b0;
              state_q  <= ACCUM;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.acc_re_o    = acc_re_q;
  assign bus.acc_im_o    = acc_im_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.sat_o       = sat_q;
  assign bus.drop_o      = drop_q;

endmodule
